// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage slice.
package fetch_pkg;
  localparam int XLEN           = 32;
  localparam int QDEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and decode handshake bundle of the fetch stage.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_instr,
    output id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear; DEPTH must be a power of two.
// Used both as the decode queue and as the in-flight PC log.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // Pointer and occupancy tracking; clear empties the FIFO like reset does.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; when full, a same-cycle pop frees the slot the tail writes.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {(AW+1){1'b0}});
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: credit-limited instruction requests, in-flight PC log and decode queue.
// Define FETCH_PERF_EN to add the perf_drop_cnt / perf_bubble_cnt counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_stall,
  fetch_if.master         bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(QDEPTH);

  logic [CW-1:0] inflight_s;
  logic [CW-1:0] qcount_s;
  logic [CW-1:0] drop_cnt_r;
  logic [CW:0]   credit_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          infl_empty_s;
  logic          rsp_take_s;
  logic          rsp_drop_s;
  logic          q_push_s;
  logic          q_pop_s;
  logic          q_empty_s;
  logic          id_valid_s;
  logic [XLEN-1:0] rsp_pc_s;
  fetch_entry_t  q_wdata_s;
  fetch_entry_t  q_head_s;

  // Every request holds a slot until its instruction leaves the queue, so the queue cannot overflow.
  assign credit_s    = {1'b0, inflight_s} + {1'b0, qcount_s};
  assign req_valid_s = ~rst & ~flush & (credit_s < CREDIT_LIMIT);
  assign req_fire_s  = req_valid_s & bus.imem_req_ready;

  // A response with nothing logged in flight is a leftover from before a reset.
  assign rsp_take_s  = bus.imem_rsp_valid & ~rst & ~infl_empty_s;
  assign rsp_drop_s  = rsp_take_s & (flush | (drop_cnt_r != {CW{1'b0}}));
  assign q_push_s    = rsp_take_s & ~rsp_drop_s;
  assign id_valid_s  = ~q_empty_s & ~rst;
  assign q_pop_s     = id_valid_s & bus.id_ready;

  assign q_wdata_s.pc    = rsp_pc_s;
  assign q_wdata_s.instr = bus.imem_rsp_data;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (req_fire_s),
    .wdata (pc_in),
    .pop   (rsp_take_s),
    .rdata (rsp_pc_s),
    .count (inflight_s),
    .empty (infl_empty_s)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (q_push_s),
    .wdata (q_wdata_s),
    .pop   (q_pop_s),
    .rdata (q_head_s),
    .count (qcount_s),
    .empty (q_empty_s)
  );

  // Responses still owed to requests issued before the most recent flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= {CW{1'b0}};
    end else if (flush) begin
      drop_cnt_r <= inflight_s - {{(CW-1){1'b0}}, rsp_take_s};
    end else if (rsp_drop_s) begin
      drop_cnt_r <= drop_cnt_r - CW'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_in;
  assign pc_stall           = ~req_fire_s;
  assign bus.id_valid       = id_valid_s;
  assign bus.id_pc          = q_head_s.pc;
  assign bus.id_instr       = q_head_s.instr;

`ifdef FETCH_PERF_EN
  logic [CW-1:0] flushed_s;
  logic [31:0]   perf_drop_r;
  logic [31:0]   perf_bubble_r;

  // An entry handed to decode in the flush cycle is not counted as flushed.
  assign flushed_s = flush ? (qcount_s - {{(CW-1){1'b0}}, q_pop_s}) : {CW{1'b0}};

  // Discarded-instruction and decode-starvation counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_drop_r   <= 32'd0;
      perf_bubble_r <= 32'd0;
    end else begin
      perf_drop_r <= perf_drop_r + 32'(flushed_s) + {31'd0, rsp_drop_s};
      if (bus.id_ready && !id_valid_s) perf_bubble_r <= perf_bubble_r + 32'd1;
      else                             perf_bubble_r <= perf_bubble_r;
    end
  end

  assign perf_drop_cnt   = perf_drop_r;
  assign perf_bubble_cnt = perf_bubble_r;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table, hand-written flush/reset sequences and
// randomized traffic checked against a transaction-level model of the fetch stream.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_stall;
  fetch_if     bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_stage #(.QDEPTH(QD)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .flush    (flush),
    .pc_stall (pc_stall),
    .bus      (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_drop_cnt   (perf_drop_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Model: memory requests outstanding (tagged with a flush epoch) and the instruction queue.
  typedef struct { logic [31:0] pc; int due; int epoch; } mem_t;
  mem_t        mem_q[$];
  logic [31:0] mq[$];
  logic [31:0] dec_log[$];
  int          dec_cyc[$];
  int          epoch, cyc, last_due, first_rsp_cyc, lat_min, lat_max;
  int          exp_pdrop, exp_pbub;
  logic [31:0] pc_reg, flush_target;

  typedef struct {
    logic [31:0] pc; logic rsp; logic [31:0] rsp_pc; logic idr;
    logic exp_rv; logic exp_idv; logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[8];

  typedef struct { int cycles; int lmin; int lmax; int idr_pct; int rqr_pct; int fl_pct; } cfg_t;
  cfg_t rc[4];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'd2654435761) ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear(input logic [31:0] pc0);
    mem_q.delete(); mq.delete(); dec_log.delete(); dec_cyc.delete();
    epoch = 0; cyc = 0; last_due = -1; first_rsp_cyc = -1;
    exp_pdrop = 0; exp_pbub = 0; pc_reg = pc0;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst = 1'b1; flush = 1'b0; pc_in = pc0;
    bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_req_valid", bus.imem_req_valid, 32'd0);
      check("rst_pc_stall", pc_stall, 32'd1);
      check("rst_id_valid", bus.id_valid, 32'd0);
      @(posedge clk); @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
    end
    rst = 1'b0;
    model_clear(pc0);
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic f, input logic idr, input logic rqr);
    mem_t m;
    logic rsp, acc, dec, exp_rv;
    flush = f; bus.id_ready = idr; bus.imem_req_ready = rqr; pc_in = pc_reg;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? instr_of(mem_q[0].pc) : 32'h0BAD_0BAD;
    #1;
    exp_rv = !f && ((mem_q.size() + mq.size()) < QD);
    check("req_valid", bus.imem_req_valid, exp_rv);
    check("pc_stall", pc_stall, !(exp_rv && rqr));
    check("req_addr", bus.imem_req_addr, pc_reg);
    check("id_valid", bus.id_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("id_pc", bus.id_pc, mq[0]);
      check("id_instr", bus.id_instr, instr_of(mq[0]));
    end
    acc = exp_rv && rqr;
    dec = (mq.size() > 0) && idr;
    if (idr && mq.size() == 0) exp_pbub++;
    @(posedge clk);
    if (dec) begin
      dec_log.push_back(mq[0]); dec_cyc.push_back(cyc); void'(mq.pop_front());
    end
    if (rsp) begin
      m = mem_q.pop_front();
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (f || m.epoch != epoch) exp_pdrop++;
      else mq.push_back(m.pc);
    end
    if (acc) begin
      m.pc = pc_reg; m.epoch = epoch;
      m.due = cyc + int'($urandom_range(lat_max, lat_min));
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
    end
    if (f) begin
      exp_pdrop += mq.size(); mq.delete(); epoch++; pc_reg = flush_target;
    end else if (acc) begin
      pc_reg = pc_reg + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_decode(input string name, input logic [31:0] exp_pc);
    int budget;
    budget = 0;
    while (dec_log.size() == 0 && budget < 40) begin
      step(1'b0, 1'b1, 1'b1);
      budget++;
    end
    check({name, "_decoded"}, dec_log.size() > 0, 32'd1);
    if (dec_log.size() > 0) check({name, "_first_pc"}, dec_log[0], exp_pc);
  endtask

  task automatic perf_check(input string name);
`ifdef FETCH_PERF_EN
    check({name, "_perf_drop"}, perf_drop_cnt, exp_pdrop);
    check({name, "_perf_bubble"}, perf_bubble_cnt, exp_pbub);
`else
    n_chk = n_chk + 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00};
    vt[1] = '{32'h04, 1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00};
    vt[2] = '{32'h08, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h00};
    vt[3] = '{32'h08, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00};
    vt[4] = '{32'h08, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00};
    vt[5] = '{32'h08, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04};
    vt[6] = '{32'h0C, 1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 32'h00};
    vt[7] = '{32'h10, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h08};
    rc[0] = '{400, 1, 1, 80, 90, 3};
    rc[1] = '{400, 1, 5, 50, 70, 5};
    rc[2] = '{400, 2, 8, 30, 100, 10};
    rc[3] = '{400, 1, 3, 100, 50, 0};

    // Back-pressured decode: two requests fill the credit, then drain in order.
    do_reset(32'h0);
    for (int i = 0; i < 8; i++) begin
      pc_in = vt[i].pc; flush = 1'b0; bus.imem_req_ready = 1'b1;
      bus.id_ready = vt[i].idr; bus.imem_rsp_valid = vt[i].rsp;
      bus.imem_rsp_data = instr_of(vt[i].rsp_pc);
      #1;
      check($sformatf("vec%0d_req_valid", i), bus.imem_req_valid, vt[i].exp_rv);
      check($sformatf("vec%0d_pc_stall", i), pc_stall, !vt[i].exp_rv);
      check($sformatf("vec%0d_id_valid", i), bus.id_valid, vt[i].exp_idv);
      if (vt[i].exp_idv) begin
        check($sformatf("vec%0d_id_pc", i), bus.id_pc, vt[i].exp_pc);
        check($sformatf("vec%0d_id_instr", i), bus.id_instr, instr_of(vt[i].exp_pc));
      end
      @(posedge clk); @(negedge clk);
    end
    bus.imem_rsp_valid = 1'b0;

    // Zero-wait memory streaming from pc 0.
    do_reset(32'h0);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
    check("stream_count", dec_log.size() >= 3, 32'd1);
    if (dec_log.size() >= 3) begin
      check("stream_pc0", dec_log[0], 32'h0);
      check("stream_pc1", dec_log[1], 32'h4);
      check("stream_pc2", dec_log[2], 32'h8);
      check("stream_latency", dec_cyc[0], first_rsp_cyc + 1);
    end
    perf_check("stream");

    // Latency 3, two in flight, redirect to 0x100.
    do_reset(32'h0);
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    flush_target = 32'h100;
    step(1'b1, 1'b1, 1'b1);
    run_until_decode("redirect", 32'h100);
`ifdef FETCH_PERF_EN
    check("redirect_drop2", perf_drop_cnt, 32'd2);
`endif
    perf_check("redirect");

    // Flush coinciding with a response, followed by a second flush.
    do_reset(32'h0);
    lat_min = 2; lat_max = 2;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    flush_target = 32'h200;
    step(1'b1, 1'b1, 1'b1);
    flush_target = 32'h300;
    step(1'b1, 1'b1, 1'b1);
    run_until_decode("double_flush", 32'h300);
    perf_check("double_flush");

    // Reset with a queued entry and one request in flight; the late response must vanish.
    do_reset(32'h0);
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 1'b1);
    lat_min = 6; lat_max = 6;
    step(1'b0, 1'b0, 1'b1);
    check("pre_rst_id_valid", bus.id_valid, 32'd1);
    rst = 1'b1; bus.id_ready = 1'b0; bus.imem_rsp_valid = 1'b0; pc_in = 32'h400;
    #1;
    check("mid_rst_id_valid", bus.id_valid, 32'd0);
    check("mid_rst_req_valid", bus.imem_req_valid, 32'd0);
    check("mid_rst_pc_stall", pc_stall, 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.imem_req_ready = 1'b0; bus.id_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = instr_of(32'h4);
    #1;
    check("post_rst_id_valid", bus.id_valid, 32'd0);
    @(posedge clk); @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    #1;
    check("late_rsp_ignored", bus.id_valid, 32'd0);
    @(posedge clk); @(negedge clk);
    model_clear(32'h400);
    lat_min = 1; lat_max = 2;
    run_until_decode("after_rst", 32'h400);

    // Randomized traffic against the model.
    for (int c = 0; c < 4; c++) begin
      do_reset(32'($urandom_range(255, 0)) << 2);
      lat_min = rc[c].lmin; lat_max = rc[c].lmax;
      for (int i = 0; i < rc[c].cycles; i++) begin
        flush_target = 32'($urandom_range(1023, 0)) << 2;
        step(int'($urandom_range(99, 0)) < rc[c].fl_pct,
             int'($urandom_range(99, 0)) < rc[c].idr_pct,
             int'($urandom_range(99, 0)) < rc[c].rqr_pct);
      end
      perf_check($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
